// File: rtl/useq_controller.sv
// useq_controller: microprogram sequencer driving a 256 x 29 asynchronous microcode ROM.
// Optional feature: define USEQ_SINGLE_STEP_EN to add dbg_step_i for single-stepping out of HALT.
module useq_controller #(
  parameter int OPC_W   = 5,
  parameter int NUM_OPS = 19,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             flag_z_i,
  input  logic             flag_n_i,
  input  logic             flag_c_i,
  input  logic             mem_ready_i,
  input  logic             halt_req_i,
`ifdef USEQ_SINGLE_STEP_EN
  input  logic             dbg_step_i,
`endif
  input  logic [28:0]      uword_i,
  output logic [7:0]       uaddr_o,
  output logic [28:0]      ctrl_o,
  output logic             ctrl_valid_o,
  output logic             halted_o,
  output logic             illegal_op_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_e;

  localparam logic [OPC_W:0] NumOpsW = (OPC_W + 1)'(NUM_OPS);

  state_e           state_q;
  logic [7:0]       uaddr_q, uaddr_d;
  logic [28:0]      ctrl_q;
  logic             ctrl_valid_q;
  logic             illegal_op_q;
  logic             trapped_q;
  logic [CNT_W-1:0] instr_count_q;

  logic [3:0] cond;
  logic [2:0] mode;
  logic       condTrue;
  logic       opLegal;
  logic [7:0] incAddr;
  logic       legalDispatch, illegalDispatch;
  logic       stepGo, stepBack;

`ifdef USEQ_SINGLE_STEP_EN
  logic stepped_q;
  assign stepGo   = (state_q == HALT) && halt_req_i && dbg_step_i && !trapped_q;
  assign stepBack = stepped_q && (state_q == RUN);
`else
  assign stepGo   = 1'b0;
  assign stepBack = 1'b0;
`endif

  // Next micro-address from the sequencing field; a +1 that would leave the 8-slot block returns to 0x00.
  always_comb begin
    cond            = uword_i[6:3];
    mode            = uword_i[2:0];
    legalDispatch   = 1'b0;
    illegalDispatch = 1'b0;
    unique case (cond)
      4'b0001: condTrue = 1'b1;
      4'b0010: condTrue = flag_z_i;
      4'b0011: condTrue = flag_n_i;
      4'b0100: condTrue = flag_c_i;
      default: condTrue = 1'b0;
    endcase
    opLegal = (opcode_i != '0) && ({1'b0, opcode_i} < NumOpsW);
    incAddr = (uaddr_q[2:0] == 3'd7) ? 8'h00 : uaddr_q + 8'd1;
    if (uword_i == '0) begin
      uaddr_d = 8'h00;
    end else if (mode == 3'b101) begin
      if (opLegal) begin
        uaddr_d       = 8'({opcode_i, 3'b000});
        legalDispatch = 1'b1;
      end else begin
        uaddr_d         = 8'h00;
        illegalDispatch = 1'b1;
      end
    end else if (mode == 3'b010) begin
      uaddr_d = condTrue ? incAddr : 8'h00;
    end else begin
      uaddr_d = incAddr;
    end
  end

  // A STALL cycle that sees mem_ready high evaluates the held word directly, so it runs exactly once.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= RUN;
      uaddr_q       <= 8'h00;
      ctrl_q        <= '0;
      ctrl_valid_q  <= 1'b0;
      illegal_op_q  <= 1'b0;
      trapped_q     <= 1'b0;
      instr_count_q <= '0;
`ifdef USEQ_SINGLE_STEP_EN
      stepped_q     <= 1'b0;
`endif
    end else begin
      illegal_op_q <= 1'b0;
      if (stepBack) begin
        state_q      <= HALT;
        ctrl_q       <= '0;
        ctrl_valid_q <= 1'b0;
`ifdef USEQ_SINGLE_STEP_EN
        stepped_q    <= 1'b0;
`endif
      end else if (state_q == HALT && !stepGo) begin
        ctrl_q       <= '0;
        ctrl_valid_q <= 1'b0;
        if (!trapped_q && !halt_req_i) begin
          state_q <= RUN;
        end
      end else if (!mem_ready_i && !stepGo) begin
        state_q      <= STALL;
        ctrl_valid_q <= 1'b0;
      end else if (illegalDispatch) begin
        state_q      <= HALT;
        trapped_q    <= 1'b1;
        illegal_op_q <= 1'b1;
        uaddr_q      <= 8'h00;
        ctrl_q       <= '0;
        ctrl_valid_q <= 1'b0;
      end else if (uaddr_d == 8'h00 && halt_req_i && !stepGo) begin
        state_q      <= HALT;
        uaddr_q      <= 8'h00;
        ctrl_q       <= '0;
        ctrl_valid_q <= 1'b0;
      end else begin
        state_q      <= RUN;
        ctrl_q       <= uword_i;
        ctrl_valid_q <= 1'b1;
        uaddr_q      <= uaddr_d;
        if (legalDispatch) begin
          instr_count_q <= instr_count_q + CNT_W'(1);
        end
`ifdef USEQ_SINGLE_STEP_EN
        stepped_q    <= stepGo;
`endif
      end
    end
  end

  assign uaddr_o       = uaddr_q;
  assign ctrl_o        = ctrl_q;
  assign ctrl_valid_o  = ctrl_valid_q;
  assign halted_o      = (state_q == HALT);
  assign illegal_op_o  = illegal_op_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_useq_controller.sv
// tb_useq_controller: directed and randomized checks of useq_controller against a behavioural model
// with a stub ROM held in the bench.
module tb_useq_controller;

  logic        clk = 1'b0;
  logic        reset, flagZ, flagN, flagC, memReady, haltReq;
  logic [4:0]  opcode;
  logic [28:0] uword;
  logic [7:0]  uaddr;
  logic [28:0] ctrl;
  logic        ctrlValid, halted, illegalOp;
  logic [15:0] instrCount;

  logic [28:0] rom [256];

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: plain integers describing what the sequencer should present.
  int          mAddr, mCount;
  logic [28:0] mCtrl;
  bit          mValid, mHalted, mTrapped, mIllegal;

  always #5 clk = ~clk;

  useq_controller dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .opcode_i     (opcode),
    .flag_z_i     (flagZ),
    .flag_n_i     (flagN),
    .flag_c_i     (flagC),
    .mem_ready_i  (memReady),
    .halt_req_i   (haltReq),
    .uword_i      (uword),
    .uaddr_o      (uaddr),
    .ctrl_o       (ctrl),
    .ctrl_valid_o (ctrlValid),
    .halted_o     (halted),
    .illegal_op_o (illegalOp),
    .instr_count_o(instrCount)
  );

  assign uword = rom[uaddr];

  function automatic logic [28:0] mkWord(input logic [21:0] payload, input logic [3:0] cond,
                                         input logic [2:0] mode);
    return {payload, cond, mode};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of the sequencer as the rules describe it, advanced at each rising edge.
  task automatic modelStep();
    logic [28:0] w;
    int cond, mode, seqNext, nxt, op;
    bit condOk, trap, disp;
    if (reset) begin
      mAddr = 0; mCount = 0; mCtrl = '0;
      mValid = 0; mHalted = 0; mTrapped = 0; mIllegal = 0;
      return;
    end
    mIllegal = 0;
    if (mHalted) begin
      mCtrl = '0;
      mValid = 0;
      if (!mTrapped && !haltReq) mHalted = 0;
      return;
    end
    if (!memReady) begin
      mValid = 0;
      return;
    end
    w       = rom[mAddr];
    cond    = int'(w[6:3]);
    mode    = int'(w[2:0]);
    op      = int'(opcode);
    condOk  = (cond == 1) || (cond == 2 && flagZ) || (cond == 3 && flagN) || (cond == 4 && flagC);
    seqNext = (mAddr % 8 == 7) ? 0 : mAddr + 1;
    trap    = 0;
    disp    = 0;
    if (w == 0) nxt = 0;
    else if (mode == 5) begin
      if (op >= 1 && op < 19) begin nxt = op * 8; disp = 1; end
      else begin nxt = 0; trap = 1; end
    end
    else if (mode == 2) nxt = condOk ? seqNext : 0;
    else nxt = seqNext;
    if (trap) begin
      mIllegal = 1; mHalted = 1; mTrapped = 1;
      mAddr = 0; mCtrl = '0; mValid = 0;
    end else if (nxt == 0 && haltReq) begin
      mHalted = 1; mAddr = 0; mCtrl = '0; mValid = 0;
    end else begin
      mCtrl = w; mValid = 1; mAddr = nxt;
      if (disp) mCount = (mCount + 1) % 65536;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, " uaddr"},       32'(uaddr),      32'(mAddr));
    checkOutput({tag, " ctrl"},        32'(ctrl),       32'(mCtrl));
    checkOutput({tag, " ctrl_valid"},  32'(ctrlValid),  32'(mValid));
    checkOutput({tag, " halted"},      32'(halted),     32'(mHalted));
    checkOutput({tag, " illegal_op"},  32'(illegalOp),  32'(mIllegal));
    checkOutput({tag, " instr_count"}, 32'(instrCount), 32'(mCount));
  endtask

  task automatic applyStimulus(input bit rst, input logic [4:0] op, input bit z, input bit n, input bit c,
                               input bit ready, input bit halt, input string tag);
    reset = rst; opcode = op; flagZ = z; flagN = n; flagC = c; memReady = ready; haltReq = halt;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic loadBasicRom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = mkWord(22'h1, 4'd0, 3'd5);
    rom[8] = mkWord(22'h2A, 4'd0, 3'd0);
    rom[9] = '0;
  endtask

  initial begin
    logic [7:0] expSeq [3];
    expSeq = '{8'h08, 8'h09, 8'h00};
    reset = 1'b1; opcode = '0; flagZ = 0; flagN = 0; flagC = 0; memReady = 1; haltReq = 0;
    mAddr = 0; mCount = 0; mCtrl = '0; mValid = 0; mHalted = 0; mTrapped = 0; mIllegal = 0;
    loadBasicRom();
    @(negedge clk);

    // Reset, then dispatch / sequential / end-of-routine.
    applyStimulus(1, 5'd1, 0, 0, 0, 1, 0, "reset");
    checkOutput("reset uaddr", 32'(uaddr), 32'h0);
    checkOutput("reset valid", 32'(ctrlValid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "basic");
      checkOutput("basic seq", 32'(uaddr), 32'(expSeq[i]));
      checkOutput("basic valid", 32'(ctrlValid), 32'h1);
    end
    checkOutput("basic count", 32'(instrCount), 32'h1);

    // Conditional on Z at 0x58.
    rom[8'h58] = mkWord(22'h33, 4'd2, 3'd2);
    rom[8'h59] = '0;
    for (int zv = 1; zv >= 0; zv--) begin
      applyStimulus(1, 5'd11, 0, 0, 0, 1, 0, "cond reset");
      applyStimulus(0, 5'd11, bit'(zv), 0, 0, 1, 0, "cond dispatch");
      checkOutput("cond dispatch addr", 32'(uaddr), 32'h58);
      applyStimulus(0, 5'd11, bit'(zv), 0, 0, 1, 0, "cond eval");
      checkOutput("cond next", 32'(uaddr), (zv == 1) ? 32'h59 : 32'h00);
    end

    // Memory stall while sitting at 0x09.
    rom[9]     = mkWord(22'h15, 4'd0, 3'd1);
    rom[8'h0A] = '0;
    applyStimulus(1, 5'd1, 0, 0, 0, 1, 0, "stall reset");
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "stall pre");
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "stall pre");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 5'd1, 0, 0, 0, 0, 0, "stall");
      checkOutput("stall uaddr", 32'(uaddr), 32'h09);
      checkOutput("stall ctrl", 32'(ctrl), 32'(rom[8]));
      checkOutput("stall valid", 32'(ctrlValid), 32'h0);
    end
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "stall resume");
    checkOutput("resume ctrl", 32'(ctrl), 32'(rom[9]));
    checkOutput("resume uaddr", 32'(uaddr), 32'h0A);
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "stall after");
    checkOutput("after uaddr", 32'(uaddr), 32'h00);

    // Illegal opcode trap is sticky until reset.
    loadBasicRom();
    applyStimulus(1, 5'd0, 0, 0, 0, 1, 0, "trap reset");
    applyStimulus(0, 5'd0, 0, 0, 0, 1, 0, "trap");
    checkOutput("trap pulse", 32'(illegalOp), 32'h1);
    checkOutput("trap halted", 32'(halted), 32'h1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 5'd1, 0, 0, 0, 1, bit'(i % 2), "trap hold");
    checkOutput("trap sticky", 32'(halted), 32'h1);
    applyStimulus(1, 5'd1, 0, 0, 0, 1, 0, "trap clear");
    checkOutput("trap cleared", 32'(halted), 32'h0);

    // halt_req raised mid-routine takes effect only at the routine end.
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "halt pre");
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 1, "halt mid");
    checkOutput("halt mid uaddr", 32'(uaddr), 32'h09);
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 1, "halt enter");
    checkOutput("halt entered", 32'(halted), 32'h1);
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 1, "halt hold");
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "halt exit");
    checkOutput("halt left", 32'(halted), 32'h0);
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "halt resume");
    checkOutput("halt resume uaddr", 32'(uaddr), 32'h08);

    // Slot boundary wrap from 0x0F.
    for (int i = 8; i < 16; i++) rom[i] = mkWord(22'(i), 4'd0, 3'd0);
    applyStimulus(1, 5'd1, 0, 0, 0, 1, 0, "wrap reset");
    for (int i = 0; i < 8; i++) applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "wrap walk");
    checkOutput("wrap at 0F", 32'(uaddr), 32'h0F);
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "wrap");
    checkOutput("wrap to 00", 32'(uaddr), 32'h00);

    // Instruction counter wrap: 0x08 dispatches back to itself every cycle.
    rom[8] = mkWord(22'h5, 4'd0, 3'd5);
    applyStimulus(1, 5'd1, 0, 0, 0, 1, 0, "cnt reset");
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "cnt first");
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      modelStep();
    end
    @(negedge clk);
    compareAll("cnt loop");
    checkOutput("cnt max", 32'(instrCount), 32'hFFFF);
    applyStimulus(0, 5'd1, 0, 0, 0, 1, 0, "cnt wrap");
    checkOutput("cnt wrapped", 32'(instrCount), 32'h0);

    // Randomized ROM contents and inputs against the model.
    for (int i = 0; i < 256; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) rom[i] = '0;
      else if (kind <= 2) rom[i] = mkWord(22'($urandom), 4'($urandom), 3'd5);
      else if (kind <= 5) rom[i] = mkWord(22'($urandom), 4'($urandom_range(0, 7)), 3'd2);
      else rom[i] = mkWord(22'($urandom), 4'($urandom), 3'($urandom_range(0, 1) == 0 ? 0 : 3));
    end
    applyStimulus(1, 5'd1, 0, 0, 0, 1, 0, "rand reset");
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] op;
      bit rst;
      op  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 18));
      rst = (mTrapped && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      applyStimulus(rst, op, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 7) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
